// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Scoreboard-based RAW hazard detection for an in-order pipeline.
//             Tracks destination registers of instructions in E..W, raises a
//             same-cycle decode stall when a source is not yet available, and
//             registers per-operand forward selects aligned with stage E.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
   parameter  int NUM_STAGES = 3,
   parameter  int REG_AW     = 5,
   parameter  int CNT_W      = 32,
   localparam int SW         = $clog2(NUM_STAGES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_D,
   input  logic [REG_AW-1:0] rs1_addr_D,
   input  logic [REG_AW-1:0] rs2_addr_D,
   input  logic              rs1_used_D,
   input  logic              rs2_used_D,
   input  logic [REG_AW-1:0] rd_addr_D,
   input  logic              rd_wen_D,
   input  logic [SW-1:0]     rdy_stg_D,
   input  logic              stall_ext,
   input  logic              flush,
   output logic              stall_D,
   output logic [SW-1:0]     fwd_rs1_E,
   output logic [SW-1:0]     fwd_rs2_E,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [SW-1:0] RDY_MIN = SW'(2);
   localparam logic [SW-1:0] RDY_MAX = SW'(NUM_STAGES);

   // Scoreboard: entry k describes the instruction currently in stage k.
   logic              sb_vld_q [1:NUM_STAGES];
   logic [REG_AW-1:0] sb_rd_q  [1:NUM_STAGES];
   logic [SW-1:0]     sb_rdy_q [1:NUM_STAGES];

   logic [SW-1:0]     fwd_rs1_q, fwd_rs1_d;
   logic [SW-1:0]     fwd_rs2_q, fwd_rs2_d;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic              new_vld;
   logic [SW-1:0]     new_rdy;
   logic              issue;
   logic              hz1, hz2;
   logic [SW-1:0]     sel1, sel2;

   // Youngest-match lookup: returns {hazard, forward_select}. The scan runs
   // oldest to youngest so the youngest matching stage overwrites the result.
   // The oldest stage is skipped: the register file writes before it reads.
   function automatic logic [SW:0] lookup(input logic used,
                                          input logic [REG_AW-1:0] addr);
      logic [SW:0] res;
      res = '0;
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
         if (used && sb_vld_q[k] && (sb_rd_q[k] == addr)) begin
            if (SW'(k + 1) < sb_rdy_q[k]) begin
               res = {1'b1, {SW{1'b0}}};
            end else begin
               res = {1'b0, SW'(k + 1)};
            end
         end
      end
      return res;
   endfunction

   // New entry fields: x0 never tracked, ready stage clamped to [2, NUM_STAGES].
   always_comb begin
      new_vld = valid_D & rd_wen_D & (rd_addr_D != '0);
      new_rdy = rdy_stg_D;
      if (rdy_stg_D < RDY_MIN) begin
         new_rdy = RDY_MIN;
      end else if (rdy_stg_D > RDY_MAX) begin
         new_rdy = RDY_MAX;
      end
   end

   // Operand lookups, stall decision and next forward selects.
   always_comb begin
      {hz1, sel1} = lookup(rs1_used_D, rs1_addr_D);
      {hz2, sel2} = lookup(rs2_used_D, rs2_addr_D);
      stall_D     = valid_D & ~flush & (hz1 | hz2);
      issue       = valid_D & ~stall_D & ~flush;
      fwd_rs1_d   = issue ? sel1 : '0;
      fwd_rs2_d   = issue ? sel2 : '0;
   end

   // Scoreboard shift, forward-select registers and saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            sb_vld_q[k] <= 1'b0;
            sb_rd_q[k]  <= '0;
            sb_rdy_q[k] <= RDY_MIN;
         end
         fwd_rs1_q   <= '0;
         fwd_rs2_q   <= '0;
         stall_cnt_q <= '0;
      end else if (!stall_ext) begin
         sb_vld_q[1] <= issue & new_vld;
         sb_rd_q[1]  <= rd_addr_D;
         sb_rdy_q[1] <= new_rdy;
         // A flush kills the instruction leaving E on its way into stage 2.
         for (int k = 2; k <= NUM_STAGES; k++) begin
            sb_vld_q[k] <= sb_vld_q[k-1] & ~(flush & (k == 2));
            sb_rd_q[k]  <= sb_rd_q[k-1];
            sb_rdy_q[k] <= sb_rdy_q[k-1];
         end
         fwd_rs1_q <= fwd_rs1_d;
         fwd_rs2_q <= fwd_rs2_d;
         if (stall_D && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   assign fwd_rs1_E = fwd_rs1_q;
   assign fwd_rs2_E = fwd_rs2_q;
   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
